// File: rtl/down_timer_pkg.sv
// Shared definitions for the down_timer_ctrl slice: FSM state encoding and default widths.
package down_timer_pkg;

    localparam int DEFAULT_WIDTH      = 4;
    localparam int DEFAULT_PRESCALE_W = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        HOLD = 3'd3,
        DONE = 3'd4
    } state_t;

    function automatic logic is_busy(input state_t s);
        return (s == LOAD) || (s == RUN) || (s == HOLD);
    endfunction

endpackage

// File: rtl/down_cnt_core.sv
// Down-count register with synchronous clear, parallel load and a non-wrapping decrement.
module down_cnt_core
    import down_timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] value_o,
    output logic             zero_o
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    // Next count: clear beats load beats decrement; zero is sticky under enable.
    always_comb begin
        value_d = value_q;
        if (clr_i) begin
            value_d = '0;
        end else if (load_i) begin
            value_d = load_val_i;
        end else if (en_i && (value_q != '0)) begin
            value_d = value_q - WIDTH'(1);
        end else begin
            value_d = value_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;
    assign zero_o  = (value_q == '0);

endmodule

// File: rtl/down_timer_ctrl.sv
// Prescaled one-shot down timer: FSM and prescaler around a down_cnt_core.
// Define DOWN_TIMER_AUTORELOAD_EN to make DONE reload the timer (periodic mode).
module down_timer_ctrl
    import down_timer_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  pause,
    input  logic [WIDTH-1:0]      load_val,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      q,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            state
);

    state_t                state_q;
    state_t                state_d;
    logic [PRESCALE_W-1:0] pc_q;
    logic [PRESCALE_W-1:0] pc_d;
    logic                  busy_q;
    logic                  done_q;

    logic                  cnt_clr_s;
    logic                  cnt_load_s;
    logic                  cnt_en_s;
    logic [WIDTH-1:0]      cnt_val_s;
    logic                  cnt_zero_s;

    down_cnt_core #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr_i      (cnt_clr_s),
        .load_i     (cnt_load_s),
        .load_val_i (load_val),
        .en_i       (cnt_en_s),
        .value_o    (cnt_val_s),
        .zero_o     (cnt_zero_s)
    );

    // Next-state, prescaler and count-control decode; stop overrides every state.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cnt_clr_s  = 1'b0;
        cnt_load_s = 1'b0;
        cnt_en_s   = 1'b0;
        if (stop) begin
            state_d   = IDLE;
            pc_d      = '0;
            cnt_clr_s = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
                LOAD: begin
                    cnt_load_s = 1'b1;
                    pc_d       = prescale;
                    if (load_val == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_d = HOLD;
                    end else if (pc_q != '0) begin
                        pc_d = pc_q - PRESCALE_W'(1);
                    end else if (cnt_zero_s) begin
                        state_d = DONE;
                    end else begin
                        // Prescaler expired: one decrement, then reload from the live prescale.
                        cnt_en_s = 1'b1;
                        pc_d     = prescale;
                        if (cnt_val_s == WIDTH'(1)) begin
                            state_d = DONE;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                HOLD: begin
                    if (!pause) begin
                        state_d = RUN;
                    end else begin
                        state_d = HOLD;
                    end
                end
                DONE: begin
                    if (start) begin
                        state_d = LOAD;
                    end else begin
`ifdef DOWN_TIMER_AUTORELOAD_EN
                        state_d = LOAD;
`else
                        state_d = IDLE;
`endif
                    end
                end
                default: begin
                    state_d   = IDLE;
                    pc_d      = '0;
                    cnt_clr_s = 1'b1;
                end
            endcase
        end
    end

    // FSM state, prescaler and registered Moore flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            busy_q  <= is_busy(state_d);
            done_q  <= (state_d == DONE);
        end
    end

    assign q     = cnt_val_s;
    assign busy  = busy_q;
    assign done  = done_q;
    assign state = state_q;

endmodule

// File: tb/tb_down_timer_ctrl.sv
// Self-checking bench for down_timer_ctrl: elapsed-time model compared every cycle plus directed literals.
module tb_down_timer_ctrl;

    localparam int W  = 4;
    localparam int PW = 4;
`ifdef DOWN_TIMER_AUTORELOAD_EN
    localparam bit AUTO_RELOAD = 1'b1;
`else
    localparam bit AUTO_RELOAD = 1'b0;
`endif

    logic          clk      = 1'b0;
    logic          reset_n  = 1'b1;
    logic          start    = 1'b0;
    logic          stop     = 1'b0;
    logic          pause    = 1'b0;
    logic [W-1:0]  load_val = '0;
    logic [PW-1:0] prescale = '0;
    logic [W-1:0]  q;
    logic          busy;
    logic          done;
    logic [2:0]    state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    down_timer_ctrl #(.WIDTH(W), .PRESCALE_W(PW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .stop     (stop),
        .pause    (pause),
        .load_val (load_val),
        .prescale (prescale),
        .q        (q),
        .busy     (busy),
        .done     (done),
        .state    (state)
    );

    // Model: 0 idle, 1 load, 2 run, 3 hold, 4 done; q derived from elapsed run cycles.
    int m_state = 0;
    int m_q     = 0;
    int m_L     = 0;
    int m_P     = 0;
    int m_e     = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_state <= 0; m_q <= 0; m_L <= 0; m_P <= 0; m_e <= 0;
        end else if (stop) begin
            m_state <= 0; m_q <= 0;
        end else begin
            case (m_state)
                0: if (start) m_state <= 1;
                1: begin
                    m_L <= int'(load_val);
                    m_P <= int'(prescale);
                    m_e <= 0;
                    m_q <= int'(load_val);
                    m_state <= (load_val == '0) ? 4 : 2;
                end
                2: begin
                    if (pause) begin
                        m_state <= 3;
                    end else begin
                        m_e <= m_e + 1;
                        m_q <= m_L - (m_e + 1) / (m_P + 1);
                        if (m_e + 1 == m_L * (m_P + 1)) m_state <= 4;
                    end
                end
                3: if (!pause) m_state <= 2;
                4: m_state <= (start || AUTO_RELOAD) ? 1 : 0;
                default: m_state <= 0;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        check("q", 32'(q), m_q);
        check("state", 32'(state), m_state);
        check("busy", 32'(busy), 32'((m_state >= 1) && (m_state <= 3)));
        check("done", 32'(done), 32'(m_state == 4));
    end

    task automatic go(input int L, input int P);
        load_val = W'(L);
        prescale = PW'(P);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while ((done !== 1'b1) && (cyc < budget));
        if (done !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_done: no done within %0d cycles", budget);
        end
    endtask

    task automatic stop_pulse();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int nd;
        #1 reset_n = 1'b0;
        #1;
        check("rst_q", 32'(q), 0);
        check("rst_state", 32'(state), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic countdown 5 with no prescale.
        go(5, 0);
        check("basic_load_state", 32'(state), 1);
        wait_done(40, c);
        check("basic_latency", c, 6);
        check("basic_q_zero", 32'(q), 0);
        @(negedge clk);
        check("basic_after_done", 32'(state), AUTO_RELOAD ? 1 : 0);
        stop_pulse();

        // Prescaled: 3 steps of 3 clocks each.
        go(3, 2);
        @(negedge clk);
        check("pre_q3_a", 32'(q), 3);
        repeat (2) @(negedge clk);
        check("pre_q3_c", 32'(q), 3);
        @(negedge clk);
        check("pre_q2", 32'(q), 2);
        wait_done(60, c);
        check("pre_tail", c, 6);
        stop_pulse();

        // Pause for 4 cycles at q=7.
        go(9, 0);
        repeat (3) @(negedge clk);
        check("pause_pre_q", 32'(q), 7);
        pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("hold_state", 32'(state), 3);
            check("hold_q", 32'(q), 7);
        end
        pause = 1'b0;
        @(negedge clk);
        check("resume_state", 32'(state), 2);
        check("resume_q7", 32'(q), 7);
        @(negedge clk);
        check("resume_q6", 32'(q), 6);
        wait_done(40, c);
        check("pause_tail", c, 6);
        stop_pulse();

        // Pause is ignored in IDLE.
        pause = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_pause", 32'(state), 0);
        pause = 1'b0;

        // Zero load goes straight to DONE.
        go(0, 3);
        check("zero_load", 32'(state), 1);
        @(negedge clk);
        check("zero_done_state", 32'(state), 4);
        check("zero_done_q", 32'(q), 0);
        check("zero_done_pulse", 32'(done), 1);
        stop_pulse();

        // Abort at q=9.
        go(12, 0);
        repeat (4) @(negedge clk);
        check("abort_pre_q", 32'(q), 9);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("abort_state", 32'(state), 0);
        check("abort_q", 32'(q), 0);
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done === 1'b1) nd++;
        end
        check("abort_no_done", nd, 0);

        // Start while busy is ignored.
        go(6, 0);
        repeat (2) @(negedge clk);
        load_val = W'(2);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        wait_done(40, c);
        check("busy_start_ignored", c, 4);
        stop_pulse();

        // Start during DONE restarts back to back.
        go(2, 0);
        wait_done(40, c);
        check("restart_first", c, 3);
        load_val = W'(3);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        check("restart_load", 32'(state), 1);
        wait_done(40, c);
        check("restart_second", c, 4);
        stop_pulse();

        // Asynchronous reset mid-run.
        go(10, 1);
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_q", 32'(q), 0);
        check("async_rst_state", 32'(state), 0);
        check("async_rst_busy", 32'(busy), 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_idle", 32'(state), 0);

`ifdef DOWN_TIMER_AUTORELOAD_EN
        // Periodic mode: done every 4 cycles until stop.
        go(2, 0);
        wait_done(40, c);
        check("auto_first", c, 3);
        for (int i = 0; i < 3; i++) begin
            wait_done(40, c);
            check("auto_period", c, 4);
        end
        stop_pulse();
        check("auto_stopped", 32'(state), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
